// File: rtl/product_accumulator.sv
// product_accumulator: sums a programmed burst of multiplier products as one 8x8 lane, two 8x8 lanes or one 16x16 value.
// Result valid the cycle after the last beat; never stalls the multiplier, holds the result until result_ready_i.
module product_accumulator #(
    parameter int LANE_W = 24,
    parameter int CNT_W  = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [1:0]            cm_i,
    input  logic [CNT_W-1:0]      burst_len_i,
    input  logic [31:0]           product_i,
    input  logic                  product_valid_i,
    input  logic                  result_ready_i,
    output logic [2*LANE_W-1:0]   acc_o,
    output logic                  result_valid_o,
    output logic [1:0]            ovf_o,
    output logic                  busy_o,
    output logic                  drop_o,
    output logic                  err_o
);

    localparam int ACC_W  = 2 * LANE_W;
    localparam int LSUM_W = LANE_W + 1;
    localparam int FSUM_W = ACC_W + 1;

    localparam logic [1:0] MODE_S8  = 2'b00;
    localparam logic [1:0] MODE_D8  = 2'b01;
    localparam logic [1:0] MODE_S16 = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ACCUM = 2'b01,
        S_HOLD  = 2'b10
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ACC_W-1:0]   r_acc;
    logic [1:0]         r_ovf;
    logic [1:0]         r_mode;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_drop;
    logic               r_err;

    logic               w_start_ok;
    logic               w_start_bad;
    logic               w_beat;
    logic               w_last;
    logic [LSUM_W-1:0]  w_lane0_sum;
    logic [LSUM_W-1:0]  w_lane1_sum;
    logic [FSUM_W-1:0]  w_full_sum;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic [1:0]         w_ovf_nxt;

    assign w_start_ok  = start_i && (burst_len_i != '0) && (cm_i != 2'b11);
    assign w_start_bad = start_i && !w_start_ok;
    assign w_beat      = (r_state == S_ACCUM) && product_valid_i;
    assign w_last      = w_beat && (r_cnt == CNT_W'(1));

    // Lane sums carry one extra bit so the carry-out feeds the sticky overflow flags.
    assign w_lane0_sum = {1'b0, r_acc[LANE_W-1:0]}     + LSUM_W'(product_i[15:0]);
    assign w_lane1_sum = {1'b0, r_acc[ACC_W-1:LANE_W]} + LSUM_W'(product_i[31:16]);
    assign w_full_sum  = {1'b0, r_acc}                 + FSUM_W'(product_i);

    always_comb begin
        w_acc_nxt = r_acc;
        w_ovf_nxt = r_ovf;
        case (r_mode)
            MODE_S8: begin
                w_acc_nxt    = {r_acc[ACC_W-1:LANE_W], w_lane0_sum[LANE_W-1:0]};
                w_ovf_nxt[0] = r_ovf[0] | w_lane0_sum[LANE_W];
            end
            MODE_D8: begin
                w_acc_nxt    = {w_lane1_sum[LANE_W-1:0], w_lane0_sum[LANE_W-1:0]};
                w_ovf_nxt[0] = r_ovf[0] | w_lane0_sum[LANE_W];
                w_ovf_nxt[1] = r_ovf[1] | w_lane1_sum[LANE_W];
            end
            MODE_S16: begin
                w_acc_nxt    = w_full_sum[ACC_W-1:0];
                w_ovf_nxt[1] = r_ovf[1] | w_full_sum[ACC_W];
            end
            default: begin
                w_acc_nxt = r_acc;
                w_ovf_nxt = r_ovf;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_last) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (result_ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_acc  <= '0;
            r_ovf  <= '0;
            r_mode <= '0;
            r_cnt  <= '0;
            r_drop <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_err  <= (r_state == S_IDLE) && w_start_bad;
            r_drop <= product_valid_i && (r_state != S_ACCUM);
            if ((r_state == S_IDLE) && w_start_ok) begin
                r_acc  <= '0;
                r_ovf  <= '0;
                r_mode <= cm_i;
                r_cnt  <= burst_len_i;
            end else if (w_beat) begin
                r_acc  <= w_acc_nxt;
                r_ovf  <= w_ovf_nxt;
                r_cnt  <= r_cnt - CNT_W'(1);
            end
        end
    end

    always_comb begin
        acc_o          = r_acc;
        ovf_o          = r_ovf;
        result_valid_o = (r_state == S_HOLD);
        busy_o         = (r_state == S_ACCUM);
        drop_o         = r_drop;
        err_o          = r_err;
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: two instances (LANE_W 24 and 16) share stimulus; a reference model
// pushes expected results to a scoreboard that is popped when result_valid_o rises.
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  cm;
    logic [7:0]  bl;
    logic [31:0] prod;
    logic        pv;
    logic        rdy;

    logic [47:0] acc_a;
    logic        rv_a, busy_a, drop_a, err_a;
    logic [1:0]  ovf_a;
    logic [31:0] acc_b;
    logic        rv_b, busy_b, drop_b, err_b;
    logic [1:0]  ovf_b;

    always #5 clk = ~clk;

    product_accumulator #(.LANE_W(24), .CNT_W(8)) dut_a (
        .clk_i(clk), .reset_i(rst), .start_i(start), .cm_i(cm), .burst_len_i(bl),
        .product_i(prod), .product_valid_i(pv), .result_ready_i(rdy),
        .acc_o(acc_a), .result_valid_o(rv_a), .ovf_o(ovf_a), .busy_o(busy_a),
        .drop_o(drop_a), .err_o(err_a)
    );

    product_accumulator #(.LANE_W(16), .CNT_W(8)) dut_b (
        .clk_i(clk), .reset_i(rst), .start_i(start), .cm_i(cm), .burst_len_i(bl),
        .product_i(prod), .product_valid_i(pv), .result_ready_i(rdy),
        .acc_o(acc_b), .result_valid_o(rv_b), .ovf_o(ovf_b), .busy_o(busy_b),
        .drop_o(drop_b), .err_o(err_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [63:0] acc_a;
        logic [1:0]  ovf_a;
        logic [63:0] acc_b;
        logic [1:0]  ovf_b;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] m_acc[2];
    logic [1:0]  m_ovf[2];
    int          lw[2] = '{24, 16};
    logic [1:0]  m_mode;
    int          m_cnt;

    task automatic model_step(input logic [31:0] p);
        for (int k = 0; k < 2; k++) begin
            logic [63:0] lm, l0, l1, s;
            lm = (64'd1 << lw[k]) - 64'd1;
            l0 = m_acc[k] & lm;
            l1 = (m_acc[k] >> lw[k]) & lm;
            case (m_mode)
                2'b00: begin
                    s = l0 + {48'd0, p[15:0]};
                    if ((s >> lw[k]) != 0) m_ovf[k][0] = 1'b1;
                    m_acc[k] = (l1 << lw[k]) | (s & lm);
                end
                2'b01: begin
                    s = l0 + {48'd0, p[15:0]};
                    if ((s >> lw[k]) != 0) m_ovf[k][0] = 1'b1;
                    l0 = s & lm;
                    s = l1 + {48'd0, p[31:16]};
                    if ((s >> lw[k]) != 0) m_ovf[k][1] = 1'b1;
                    m_acc[k] = ((s & lm) << lw[k]) | l0;
                end
                default: begin
                    s = m_acc[k] + {32'd0, p};
                    if ((s >> (2 * lw[k])) != 0) m_ovf[k][1] = 1'b1;
                    m_acc[k] = s & ((64'd1 << (2 * lw[k])) - 64'd1);
                end
            endcase
        end
    endtask

    task automatic start_burst(input logic [1:0] m, input logic [7:0] len);
        start = 1'b1;
        cm    = m;
        bl    = len;
        if (len != 0 && m != 2'b11) begin
            m_mode = m;
            m_cnt  = len;
            for (int k = 0; k < 2; k++) begin
                m_acc[k] = '0;
                m_ovf[k] = '0;
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
        cm    = 2'($urandom);
        bl    = 8'($urandom);
    endtask

    task automatic beat(input logic [31:0] p);
        exp_t e;
        prod = p;
        pv   = 1'b1;
        if (m_cnt > 0) begin
            model_step(p);
            m_cnt--;
            if (m_cnt == 0) begin
                e.acc_a = m_acc[0];
                e.ovf_a = m_ovf[0];
                e.acc_b = m_acc[1];
                e.ovf_b = m_ovf[1];
                sb.push_back(e);
            end
        end
        @(posedge clk); #1;
        pv = 1'b0;
    endtask

    task automatic drain();
        rdy = 1'b1;
        @(posedge clk); #1;
        rdy = 1'b0;
        check("drain_rv", {63'd0, rv_a}, 64'd0);
    endtask

    logic prev_rv;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            prev_rv = 1'b0;
        end else begin
            if (rv_a && !prev_rv) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("sb_acc24", {16'd0, acc_a}, e.acc_a);
                    check("sb_ovf24", {62'd0, ovf_a}, {62'd0, e.ovf_a});
                    check("sb_acc16", {32'd0, acc_b}, e.acc_b);
                    check("sb_ovf16", {62'd0, ovf_b}, {62'd0, e.ovf_b});
                    check("sb_rv16", {63'd0, rv_b}, 64'd1);
                end
            end
            prev_rv = rv_a;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] hold_acc;
        rst = 1'b1; start = 1'b0; cm = '0; bl = '0; prod = '0; pv = 1'b0; rdy = 1'b0;
        m_mode = '0; m_cnt = 0;
        for (int k = 0; k < 2; k++) begin
            m_acc[k] = '0;
            m_ovf[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_outs24", {16'd0, acc_a}, 64'd0);
        check("rst_flags24", {58'd0, rv_a, ovf_a, busy_a, drop_a, err_a}, 64'd0);
        check("rst_outs16", {32'd0, acc_b}, 64'd0);
        rst = 1'b0;

        // single 16x16
        start_burst(2'b10, 8'd3);
        repeat (3) beat(32'h00828F34);
        check("t1_rv", {63'd0, rv_a}, 64'd1);
        check("t1_acc", {16'd0, acc_a}, 64'h0000_0000_0187_AD9C);
        check("t1_ovf", {62'd0, ovf_a}, 64'd0);
        drain();

        // dual 8x8, no cross-lane carry
        start_burst(2'b01, 8'd2);
        repeat (2) beat(32'h00800234);
        check("t2_acc", {16'd0, acc_a}, 64'h0000_0001_0000_0468);
        drain();

        // single 8x8 lane0 overflow at LANE_W=16, then cleared by a new start
        start_burst(2'b00, 8'd2);
        repeat (2) beat(32'h0000FFFF);
        check("t3_acc16", {32'd0, acc_b}, 64'h0000_FFFE);
        check("t3_ovf16", {62'd0, ovf_b}, 64'd1);
        check("t3_acc24", {16'd0, acc_a}, 64'h0001_FFFE);
        drain();
        start_burst(2'b00, 8'd1);
        check("t3_clr_ovf", {62'd0, ovf_b}, 64'd0);
        check("t3_busy", {63'd0, busy_b}, 64'd1);
        beat(32'h0000_0005);
        drain();

        // 16x16 carry across lanes and full-width wrap
        start_burst(2'b10, 8'd2);
        repeat (2) beat(32'hFFFF_FFFF);
        check("t16_wrap", {32'd0, acc_b}, 64'hFFFF_FFFE);
        check("t16_ovf", {62'd0, ovf_b}, 64'd2);
        drain();

        // held result under backpressure; products and start in HOLD ignored
        start_burst(2'b10, 8'd2);
        beat(32'h1234_5678);
        beat(32'h0000_ABCD);
        hold_acc = acc_a;
        pv = 1'b1; prod = $urandom; rdy = 1'b0; start = 1'b1; cm = 2'b00; bl = 8'd1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("t4_drop", {63'd0, drop_a}, 64'd1);
            check("t4_rv", {63'd0, rv_a}, 64'd1);
            check("t4_acc", {16'd0, acc_a}, {16'd0, hold_acc});
            check("t4_err", {63'd0, err_a}, 64'd0);
        end
        start = 1'b0; pv = 1'b0; rdy = 1'b1;
        @(posedge clk); #1;
        rdy = 1'b0;
        check("t4_rv_drop", {63'd0, rv_a}, 64'd0);
        check("t4_idle_busy", {63'd0, busy_a}, 64'd0);
        @(posedge clk); #1;
        check("t4_acc_kept", {16'd0, acc_a}, {16'd0, hold_acc});
        check("t4_drop_end", {63'd0, drop_a}, 64'd0);

        // dual lanes with gaps, random data, ignored start mid-burst
        start_burst(2'b01, 8'd6);
        for (int i = 0; i < 6; i++) begin
            beat($urandom);
            if (i == 2) begin
                start = 1'b1; cm = 2'b11; bl = 8'd0;
                @(posedge clk); #1;
                start = 1'b0;
                check("accum_start_err", {63'd0, err_a}, 64'd0);
                check("accum_busy", {63'd0, busy_a}, 64'd1);
            end else if (i == 4) begin
                @(posedge clk); #1;
            end
        end
        check("t_gap_rv", {63'd0, rv_a}, 64'd1);
        drain();

        // rejected starts
        hold_acc = acc_a;
        start_burst(2'b11, 8'd5);
        check("t5_err_cm", {63'd0, err_a}, 64'd1);
        check("t5_busy_cm", {63'd0, busy_a}, 64'd0);
        @(posedge clk); #1;
        check("t5_err_clr", {63'd0, err_a}, 64'd0);
        start_burst(2'b00, 8'd0);
        check("t5_err_len", {63'd0, err_a}, 64'd1);
        check("t5_busy_len", {63'd0, busy_a}, 64'd0);
        check("t5_acc", {16'd0, acc_a}, {16'd0, hold_acc});

        // reset mid-burst, then a clean burst
        start_burst(2'b10, 8'd4);
        beat(32'd1);
        beat(32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t6_acc", {16'd0, acc_a}, 64'd0);
        check("t6_flags", {58'd0, rv_a, ovf_a, busy_a, drop_a, err_a}, 64'd0);
        check("t6_busy16", {63'd0, busy_b}, 64'd0);
        start_burst(2'b10, 8'd4);
        repeat (4) beat(32'd1);
        check("t6_sum", {16'd0, acc_a}, 64'd4);
        drain();

        repeat (3) @(posedge clk);
        #1;
        check("sb_drain", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
